contador_gray: RTL

Parametrised synchronous Gray-code counter with a registered Gray output and a matching binary output. It supports up/down counting, parallel load of a Gray-coded value, and either wrap-around or saturating behaviour. It generalises the team's fixed 4-bit binary-to-Gray conversion into a stateful source of Gray sequences. Its main uses are position encoders, clock-domain-crossing pointers and display/demo sequencers.

---
 rtl/gray_pkg.sv | 26 ++
 rtl/conversor_gray_bin.sv | 16 +
 rtl/contador_gray.sv | 96 +++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code constants and conversion helpers
package gray_pkg;

    // Widest counter any instance may be built with; helpers work at this width.
    localparam int LARGURA_MAX = 16;

    typedef logic [LARGURA_MAX-1:0] vetor_max_t;

    // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
    // Callers zero-extend narrower values and truncate the result.
    function automatic vetor_max_t bin_para_gray(input vetor_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: running XOR from the MSB downwards. Zero-extended
    // upper bits decode to zero, so truncating the result is safe.
    function automatic vetor_max_t gray_para_bin(input vetor_max_t g);
        vetor_max_t b;
        b[LARGURA_MAX-1] = g[LARGURA_MAX-1];
        for (int i = LARGURA_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/conversor_gray_bin.sv
// rtl/conversor_gray_bin.sv - combinational Gray-to-binary decoder
module conversor_gray_bin
    import gray_pkg::*;
#(
    parameter int LARGURA = 4
) (
    input  logic [LARGURA-1:0] entrada,
    output logic [LARGURA-1:0] saida
);

    // Widen to the package width, decode, and keep only the live bits.
    always_comb begin
        saida = LARGURA'(gray_para_bin(LARGURA_MAX'(entrada)));
    end

endmodule

// File: rtl/contador_gray.sv
// rtl/contador_gray.sv - up/down Gray-code counter with load and wrap/saturate
module contador_gray
    import gray_pkg::*;
#(
    parameter int LARGURA = 4,
    parameter int SATURA  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               habilita,
    input  logic               sentido,
    input  logic               carrega,
    input  logic [LARGURA-1:0] entrada_gray,
    output logic [LARGURA-1:0] saida,
    output logic [LARGURA-1:0] saida_bin,
    output logic               volta
);

    localparam logic [LARGURA-1:0] VALOR_MAX = '1;
    localparam logic [LARGURA-1:0] VALOR_MIN = '0;

    // Binary count is the real state; the Gray copy is registered alongside
    // it from the same next-state value so the two outputs never disagree.
    logic [LARGURA-1:0] cont_q, cont_d;
    logic [LARGURA-1:0] gray_q, gray_d;
    logic               volta_q, volta_d;

    logic [LARGURA-1:0] carga_bin;
    logic               no_topo;
    logic               no_fundo;

    conversor_gray_bin #(
        .LARGURA(LARGURA)
    ) u_conversor_carga (
        .entrada(entrada_gray),
        .saida  (carga_bin)
    );

    // End-of-range detection for the current direction.
    always_comb begin
        no_topo  = (cont_q == VALOR_MAX);
        no_fundo = (cont_q == VALOR_MIN);
    end

    // Next-state mux: load beats counting; ends either wrap or hold, and both flag volta.
    always_comb begin
        cont_d  = cont_q;
        volta_d = 1'b0;
        if (carrega) begin
            cont_d = carga_bin;
        end else if (habilita) begin
            if (!sentido) begin
                if (!no_topo) begin
                    cont_d = cont_q + 1'b1;
                end else begin
                    volta_d = 1'b1;
                    if (SATURA == 0) begin
                        cont_d = VALOR_MIN;
                    end
                end
            end else begin
                if (!no_fundo) begin
                    cont_d = cont_q - 1'b1;
                end else begin
                    volta_d = 1'b1;
                    if (SATURA == 0) begin
                        cont_d = VALOR_MAX;
                    end
                end
            end
        end
    end

    // Gray image of the next count, registered together with it.
    always_comb begin
        gray_d = LARGURA'(bin_para_gray(LARGURA_MAX'(cont_d)));
    end

    // State and output registers; reset wins over load and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cont_q  <= '0;
            gray_q  <= '0;
            volta_q <= 1'b0;
        end else begin
            cont_q  <= cont_d;
            gray_q  <= gray_d;
            volta_q <= volta_d;
        end
    end

    assign saida     = gray_q;
    assign saida_bin = cont_q;
    assign volta     = volta_q;

endmodule
